bus_mux_arb: RTL and testbench
==============================

// Module: bus_mux_arb
// PURPOSE
//  Parametrised, registered datapath bus source selector with optional round-robin arbitration.
//  Drives the shared internal processor bus from NSRC source registers (MEM, AR, DR, RP, ... AC).
//  Mode 0 takes a microcode select, as the processor control unit issues today.
//  Mode 1 arbitrates req lines from autonomous units.
//  Output is registered: one clock from select/grant decision to bus_data.
// PARAMETERS
//  WIDTH     8   bus/source data width in bits
//  NSRC      15  number of sources; legal range 2..(2**SEL_W-1)
//  SEL_W     4   select/owner code width; code 0 = no source, code k = source k-1
//  ARB_MODE  0   0 = direct select (sel/sel_valid), 1 = round-robin request/grant
//  MAX_HOLD  4   mode 1 only: max consecutive cycles one owner keeps the bus (>=1)
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous reset, active-high
//  src_data   in   NSRC*WIDTH   flattened sources; source i at [i*WIDTH +: WIDTH]
//  sel        in   SEL_W        mode 0 source code (0 = idle)
//  sel_valid  in   1            mode 0: sel is sampled this edge
//  req        in   NSRC         mode 1 bus requests, bit i = source i
//  gnt        out  NSRC         mode 1 one-hot grant, registered; 0 in mode 0
//  bus_data   out  WIDTH        registered bus value
//  bus_valid  out  1            bus_data was loaded at the last edge
//  bus_owner  out  SEL_W        code of source currently driving (0 = none)
//  sel_err    out  1            one-cycle pulse: sel_valid with sel > NSRC
// BEHAVIOUR
//  Reset (async, any time, incl. mid-grant):
//  - bus_data=0, bus_valid=0, bus_owner=0, gnt=0, sel_err=0.
//  - state=IDLE, rr_ptr=0, hold_cnt=0.
//  - Takes effect immediately; first load occurs at the first edge after rst deasserts.
//  Mode 0, per edge:
//  - sel_valid & 1<=sel<=NSRC: bus_data<=src[sel-1], bus_valid<=1, bus_owner<=sel.
//  - sel_valid & sel==0: bus_valid<=0, bus_owner<=0, bus_data holds.
//  - sel_valid & sel>NSRC: sel_err<=1 (one cycle), bus_valid<=0, bus_owner<=0, bus_data holds.
//  - !sel_valid: bus_valid<=0, bus_owner holds, bus_data holds.
//  - req ignored; gnt stays 0.
//  Mode 1 (sel/sel_valid ignored, sel_err stays 0):
//  - FSM states: IDLE, GRANT. Owner index k is 0-based.
//  - Pick: first set req bit scanning from rr_ptr upward, wrapping NSRC-1 -> 0.
//  - IDLE:
//    - If any req: pick k; gnt<=onehot(k), bus_owner<=k+1, bus_data<=src[k],
//      bus_valid<=1, hold_cnt<=1, go GRANT.
//    - Otherwise: gnt=0, bus_valid<=0, bus_data holds.
//  - GRANT, release when !req[k] or hold_cnt==MAX_HOLD:
//    - rr_ptr<=(k+1) mod NSRC.
//    - If another req is pending (pick from the new rr_ptr, excluding k): grant it the
//      same edge (no dead cycle), hold_cnt<=1.
//    - Else: go IDLE, gnt<=0, bus_owner<=0, bus_valid<=0.
//  - GRANT, otherwise: bus_data<=src[k] (tracks live source), hold_cnt<=hold_cnt+1.
//  - Only requester at MAX_HOLD expiry: k is excluded for that edge, giving 1 idle cycle,
//    then it is re-granted.
//  - gnt is always one-hot or zero; bus_owner==index(gnt)+1 whenever gnt!=0.
//  - hold_cnt width is clog2(MAX_HOLD+1); never exceeds MAX_HOLD.
//  Elaboration error if NSRC>2**SEL_W-1, NSRC<2, or MAX_HOLD<1.
// STRUCTURE
//  Shared header bus_defs.vh holds:
//  - SEL_IDLE=0, ARB_DIRECT=0, ARB_RR=1, FSM encodings ST_IDLE/ST_GRANT.
//  Sub-module rr_pick (combinational):
//  - Inputs req, rr_ptr, exclude mask; outputs found and idx.
//  - Instantiated only under ARB_MODE==1 generate branch.
//  Top holds the output registers, FSM, hold counter and source-select mux.
// TESTING
//  - Reset: rst=1 mid-grant in mode 1 -> all outputs 0 in the same cycle; first grant
//    after release goes to the lowest requester.
//  - Mode 0 sweep: sel=1..15, src i = 8'hA0+i -> next cycle bus_data=8'hA0+(sel-1),
//    bus_valid=1, bus_owner=sel.
//  - Mode 0 idle/error (NSRC=12): sel=0 -> bus_valid=0, data held; sel=13 -> sel_err
//    one-cycle pulse, data held.
//  - Mode 1 fairness: req=all ones for 60 cycles, MAX_HOLD=4 -> grants rotate 0,1,2..14,0.
//    Each grant lasts exactly 4 cycles with no dead cycles.
//  - Mode 1 early release: req[3] alone for 2 cycles, then req[3]=0, req[5]=1 the same cycle
//    -> gnt[3] held 2 cycles, gnt[5] asserted at the next edge, bus_owner=6.
//  - Mode 1 sole requester: req[0] constant, MAX_HOLD=2 -> pattern 2 granted, 1 idle,
//    repeat; bus_valid=0 on idle cycles.

Source files
------------

// File: rtl/bus_mux_arb_pkg.sv
// Shared codes and types for the bus source selector / arbiter.
package bus_mux_arb_pkg;

  localparam int SEL_IDLE   = 0;
  localparam int ARB_DIRECT = 0;
  localparam int ARB_RR     = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Hold counter width: enough to reach MAX_HOLD, never narrower than one bit.
  function automatic int hold_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_mux_arb_if.sv
// Bus-side signal group of bus_mux_arb: sources, select/request inputs and the registered bus.
interface bus_mux_arb_if #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 15,
  parameter int SEL_W = 4
);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]      sel;
  logic                  sel_valid;
  logic [NSRC-1:0]       req;
  logic [NSRC-1:0]       gnt;
  logic [WIDTH-1:0]      bus_data;
  logic                  bus_valid;
  logic [SEL_W-1:0]      bus_owner;
  logic                  sel_err;

  modport master (
    output src_data, sel, sel_valid, req,
    input  gnt, bus_data, bus_valid, bus_owner, sel_err
  );

  modport slave (
    input  src_data, sel, sel_valid, req,
    output gnt, bus_data, bus_valid, bus_owner, sel_err
  );

endinterface

// File: rtl/bus_mux_arb_rr_pick.sv
// Round-robin picker: first request bit at or above rr_ptr (wrapping), ignoring excluded bits.
module bus_mux_arb_rr_pick
  import bus_mux_arb_pkg::*;
#(
  parameter int NSRC  = 15,
  parameter int SEL_W = 4
) (
  input  logic [NSRC-1:0]  req,
  input  logic [SEL_W-1:0] rr_ptr,
  input  logic [NSRC-1:0]  excl,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] rot;

  assign cand = req & ~excl;
  // Rotating the doubled vector puts bit rr_ptr at position 0, so the scan is a plain priority search.
  assign rot  = NSRC'({cand, cand} >> rr_ptr);

  // Lowest set bit of the rotated vector, mapped back to a source index.
  always_comb begin
    int unsigned pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 32'(rr_ptr) + i;
        if (pos >= NSRC) pos = pos - NSRC;
        idx   = SEL_W'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_mux_arb.sv
// Registered processor-bus source selector: microcode select (mode 0) or round-robin arbiter (mode 1).
module bus_mux_arb
  import bus_mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NSRC     = 15,
  parameter int SEL_W    = 4,
  parameter int ARB_MODE = ARB_DIRECT,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  bus_mux_arb_if.slave bus
);

  localparam int               NCODE     = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] NSRC_CODE = SEL_W'(NSRC);
  localparam logic [SEL_W-1:0] CODE_IDLE = SEL_W'(SEL_IDLE);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NSRC - 1);
  localparam int               HOLD_W    = hold_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  if (NSRC < 2 || NSRC > NCODE - 1) begin : g_bad_nsrc
    $error("bus_mux_arb: NSRC must be in 2..2**SEL_W-1");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("bus_mux_arb: MAX_HOLD must be >= 1");
  end
  if (ARB_MODE != ARB_DIRECT && ARB_MODE != ARB_RR) begin : g_bad_mode
    $error("bus_mux_arb: ARB_MODE must be 0 or 1");
  end

  // Sources unpacked and padded to the full code space so any SEL_W-wide index is in range.
  logic [WIDTH-1:0] src_arr [NCODE];

  for (genvar g = 0; g < NCODE; g++) begin : g_src
    if (g < NSRC) begin : g_used
      assign src_arr[g] = bus.src_data[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign src_arr[g] = '0;
    end
  end

  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [NSRC-1:0]  gnt_q,   gnt_d;
  logic             err_q,   err_d;

  // Output registers shared by both modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_data  = data_q;
  assign bus.bus_valid = valid_q;
  assign bus.bus_owner = owner_q;
  assign bus.gnt       = gnt_q;
  assign bus.sel_err   = err_q;

  if (ARB_MODE == ARB_DIRECT) begin : g_direct

    // Microcode select: load on a legal code, flag out-of-range codes, otherwise hold data.
    always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      owner_d = owner_q;
      gnt_d   = '0;
      err_d   = 1'b0;
      if (bus.sel_valid) begin
        owner_d = CODE_IDLE;
        if (bus.sel != CODE_IDLE) begin
          if (bus.sel <= NSRC_CODE) begin
            data_d  = src_arr[bus.sel - SEL_W'(1)];
            valid_d = 1'b1;
            owner_d = bus.sel;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end

  end else begin : g_rr

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SEL_W-1:0]  cur_idx;
    logic [SEL_W-1:0]  nxt_ptr;
    logic [SEL_W-1:0]  pick_ptr;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              release_bus;

    // The current owner index is recovered from the registered owner code rather than stored twice.
    assign cur_idx  = owner_q - SEL_W'(1);
    assign nxt_ptr  = (cur_idx == LAST_IDX) ? '0 : cur_idx + SEL_W'(1);
    // On a release the search already starts past the outgoing owner, so the handover needs no dead cycle.
    assign pick_ptr = (state_q == ST_GRANT) ? nxt_ptr : ptr_q;

    bus_mux_arb_rr_pick #(
      .NSRC  (NSRC),
      .SEL_W (SEL_W)
    ) u_pick (
      .req    (bus.req),
      .rr_ptr (pick_ptr),
      .excl   (gnt_q),
      .found  (pick_found),
      .idx    (pick_idx)
    );

    // Arbiter state, round-robin pointer and hold counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        ptr_q   <= '0;
        hold_q  <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        hold_q  <= hold_d;
      end
    end

    // Grant decision: new grant from IDLE, release/handover or continued hold in GRANT.
    always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      owner_d     = owner_q;
      gnt_d       = gnt_q;
      err_d       = 1'b0;
      release_bus = 1'b0;
      case (state_q)
        ST_IDLE: begin
          gnt_d   = '0;
          owner_d = CODE_IDLE;
          if (pick_found) begin
            state_d = ST_GRANT;
            gnt_d   = NSRC'(1) << pick_idx;
            owner_d = pick_idx + SEL_W'(1);
            data_d  = src_arr[pick_idx];
            valid_d = 1'b1;
            hold_d  = HOLD_W'(1);
          end
        end
        ST_GRANT: begin
          release_bus = ((bus.req & gnt_q) == '0) || (hold_q == HOLD_MAX);
          if (release_bus) begin
            ptr_d = nxt_ptr;
            if (pick_found) begin
              gnt_d   = NSRC'(1) << pick_idx;
              owner_d = pick_idx + SEL_W'(1);
              data_d  = src_arr[pick_idx];
              valid_d = 1'b1;
              hold_d  = HOLD_W'(1);
            end else begin
              state_d = ST_IDLE;
              gnt_d   = '0;
              owner_d = CODE_IDLE;
              hold_d  = '0;
            end
          end else begin
            data_d  = src_arr[cur_idx];
            valid_d = 1'b1;
            hold_d  = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          owner_d = CODE_IDLE;
        end
      endcase
    end

  end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench for bus_mux_arb: two direct-select instances and two round-robin instances.
module tb_bus_mux_arb;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_mux_arb_if #(.WIDTH(8), .NSRC(15), .SEL_W(4)) if0 ();
  bus_mux_arb_if #(.WIDTH(8), .NSRC(12), .SEL_W(4)) if1 ();
  bus_mux_arb_if #(.WIDTH(8), .NSRC(15), .SEL_W(4)) if2 ();
  bus_mux_arb_if #(.WIDTH(8), .NSRC(15), .SEL_W(4)) if3 ();

  bus_mux_arb #(.WIDTH(8), .NSRC(15), .SEL_W(4), .ARB_MODE(0), .MAX_HOLD(4)) u_dir15 (
    .clk(clk), .rst(rst), .bus(if0));
  bus_mux_arb #(.WIDTH(8), .NSRC(12), .SEL_W(4), .ARB_MODE(0), .MAX_HOLD(4)) u_dir12 (
    .clk(clk), .rst(rst), .bus(if1));
  bus_mux_arb #(.WIDTH(8), .NSRC(15), .SEL_W(4), .ARB_MODE(1), .MAX_HOLD(4)) u_rr4 (
    .clk(clk), .rst(rst), .bus(if2));
  bus_mux_arb #(.WIDTH(8), .NSRC(15), .SEL_W(4), .ARB_MODE(1), .MAX_HOLD(2)) u_rr2 (
    .clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic       sv;
    logic [7:0] d0;
    logic       v0;
    logic [3:0] o0;
    logic       e0;
    logic [7:0] d1;
    logic       v1;
    logic [3:0] o1;
    logic       e1;
  } m0_vec_t;

  m0_vec_t vecs [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_dir15(input string tag, input logic [7:0] d, input logic v,
                           input logic [3:0] o, input logic e);
    chk({tag, " data"},  32'(if0.bus_data),  32'(d));
    chk({tag, " valid"}, 32'(if0.bus_valid), 32'(v));
    chk({tag, " owner"}, 32'(if0.bus_owner), 32'(o));
    chk({tag, " err"},   32'(if0.sel_err),   32'(e));
    chk({tag, " gnt"},   32'(if0.gnt),       32'd0);
  endtask

  task automatic chk_dir12(input string tag, input logic [7:0] d, input logic v,
                           input logic [3:0] o, input logic e);
    chk({tag, " data"},  32'(if1.bus_data),  32'(d));
    chk({tag, " valid"}, 32'(if1.bus_valid), 32'(v));
    chk({tag, " owner"}, 32'(if1.bus_owner), 32'(o));
    chk({tag, " err"},   32'(if1.sel_err),   32'(e));
    chk({tag, " gnt"},   32'(if1.gnt),       32'd0);
  endtask

  task automatic chk_rr4(input string tag, input logic [14:0] g, input logic [3:0] o,
                         input logic [7:0] d, input logic v);
    chk({tag, " gnt"},   32'(if2.gnt),       32'(g));
    chk({tag, " owner"}, 32'(if2.bus_owner), 32'(o));
    chk({tag, " data"},  32'(if2.bus_data),  32'(d));
    chk({tag, " valid"}, 32'(if2.bus_valid), 32'(v));
    chk({tag, " err"},   32'(if2.sel_err),   32'd0);
  endtask

  task automatic chk_rr2(input string tag, input logic [14:0] g, input logic [3:0] o,
                         input logic [7:0] d, input logic v);
    chk({tag, " gnt"},   32'(if3.gnt),       32'(g));
    chk({tag, " owner"}, 32'(if3.bus_owner), 32'(o));
    chk({tag, " data"},  32'(if3.bus_data),  32'(d));
    chk({tag, " valid"}, 32'(if3.bus_valid), 32'(v));
    chk({tag, " err"},   32'(if3.sel_err),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned k;
    logic [14:0] g;
    checks = 0;
    errors = 0;
    rst = 1'b1;

    if0.src_data = '0; if1.src_data = '0; if2.src_data = '0; if3.src_data = '0;
    for (int i = 0; i < 15; i++) begin
      if0.src_data[i*8 +: 8] = 8'(8'hA0 + i);
      if2.src_data[i*8 +: 8] = 8'(8'hA0 + i);
      if3.src_data[i*8 +: 8] = 8'(8'hA0 + i);
    end
    for (int i = 0; i < 12; i++) if1.src_data[i*8 +: 8] = 8'(8'hA0 + i);
    if0.sel = '0; if0.sel_valid = 1'b0; if0.req = '0;
    if1.sel = '0; if1.sel_valid = 1'b0; if1.req = '0;
    if2.sel = '0; if2.sel_valid = 1'b0; if2.req = '0;
    if3.sel = '0; if3.sel_valid = 1'b0; if3.req = '0;

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    chk_dir15("reset dir15", 8'h00, 1'b0, 4'd0, 1'b0);
    chk_dir12("reset dir12", 8'h00, 1'b0, 4'd0, 1'b0);
    chk_rr4("reset rr4", 15'h0, 4'd0, 8'h00, 1'b0);
    chk_rr2("reset rr2", 15'h0, 4'd0, 8'h00, 1'b0);
    rst = 1'b0;

    // Mode 0 table: sweep sel=1..15, then idle / hold / out-of-range codes.
    for (int s = 1; s <= 15; s++) begin
      vecs[s-1].sel = 4'(s);
      vecs[s-1].sv  = 1'b1;
      vecs[s-1].d0  = 8'(8'hA0 + s - 1);
      vecs[s-1].v0  = 1'b1;
      vecs[s-1].o0  = 4'(s);
      vecs[s-1].e0  = 1'b0;
      if (s <= 12) begin
        vecs[s-1].d1 = 8'(8'hA0 + s - 1);
        vecs[s-1].v1 = 1'b1;
        vecs[s-1].o1 = 4'(s);
        vecs[s-1].e1 = 1'b0;
      end else begin
        vecs[s-1].d1 = 8'hAB;
        vecs[s-1].v1 = 1'b0;
        vecs[s-1].o1 = 4'd0;
        vecs[s-1].e1 = 1'b1;
      end
    end
    vecs[15] = '{sel: 4'd0,  sv: 1'b1, d0: 8'hAE, v0: 1'b0, o0: 4'd0,  e0: 1'b0,
                 d1: 8'hAB, v1: 1'b0, o1: 4'd0,  e1: 1'b0};
    vecs[16] = '{sel: 4'd4,  sv: 1'b1, d0: 8'hA3, v0: 1'b1, o0: 4'd4,  e0: 1'b0,
                 d1: 8'hA3, v1: 1'b1, o1: 4'd4,  e1: 1'b0};
    vecs[17] = '{sel: 4'd4,  sv: 1'b0, d0: 8'hA3, v0: 1'b0, o0: 4'd4,  e0: 1'b0,
                 d1: 8'hA3, v1: 1'b0, o1: 4'd4,  e1: 1'b0};
    vecs[18] = '{sel: 4'd13, sv: 1'b1, d0: 8'hAC, v0: 1'b1, o0: 4'd13, e0: 1'b0,
                 d1: 8'hA3, v1: 1'b0, o1: 4'd0,  e1: 1'b1};
    vecs[19] = '{sel: 4'd13, sv: 1'b0, d0: 8'hAC, v0: 1'b0, o0: 4'd13, e0: 1'b0,
                 d1: 8'hA3, v1: 1'b0, o1: 4'd0,  e1: 1'b0};
    vecs[20] = '{sel: 4'd0,  sv: 1'b0, d0: 8'hAC, v0: 1'b0, o0: 4'd13, e0: 1'b0,
                 d1: 8'hA3, v1: 1'b0, o1: 4'd0,  e1: 1'b0};

    for (int i = 0; i < 21; i++) begin
      if0.sel = vecs[i].sel; if0.sel_valid = vecs[i].sv;
      if1.sel = vecs[i].sel; if1.sel_valid = vecs[i].sv;
      @(negedge clk);
      chk_dir15($sformatf("m0[%0d] dir15", i), vecs[i].d0, vecs[i].v0, vecs[i].o0, vecs[i].e0);
      chk_dir12($sformatf("m0[%0d] dir12", i), vecs[i].d1, vecs[i].v1, vecs[i].o1, vecs[i].e1);
    end
    if0.sel_valid = 1'b0;
    if1.sel_valid = 1'b0;

    // Fairness: all requesting, each owner keeps the bus exactly 4 cycles, no gaps.
    if2.req = '1;
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      k = (c / 4) % 15;
      g = 15'd1 << k;
      chk_rr4($sformatf("fair c%0d", c), g, 4'(k + 1), 8'(8'hA0 + k), 1'b1);
    end
    if2.req = '0;
    @(negedge clk);
    chk_rr4("fair drop", 15'h0, 4'd0, 8'hA0, 1'b0);

    // Early release: source 3 for two cycles, then source 5 takes over at the next edge.
    if2.req = 15'h0008;
    @(negedge clk);
    chk_rr4("early g3a", 15'h0008, 4'd4, 8'hA3, 1'b1);
    @(negedge clk);
    chk_rr4("early g3b", 15'h0008, 4'd4, 8'hA3, 1'b1);
    if2.req = 15'h0020;
    @(negedge clk);
    chk_rr4("early g5", 15'h0020, 4'd6, 8'hA5, 1'b1);
    if2.req = '0;
    @(negedge clk);
    chk_rr4("early idle", 15'h0, 4'd0, 8'hA5, 1'b0);

    // Reset mid-grant: outputs clear immediately; afterwards the lowest requester wins.
    if2.req = 15'h0084;
    @(negedge clk);
    chk_rr4("pre-rst g7", 15'h0080, 4'd8, 8'hA7, 1'b1);
    #2 rst = 1'b1;
    #1 chk_rr4("async rst", 15'h0, 4'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk_rr4("rst held", 15'h0, 4'd0, 8'h00, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_rr4("post-rst g2", 15'h0004, 4'd3, 8'hA2, 1'b1);
    if2.req = '0;
    @(negedge clk);
    chk_rr4("post-rst idle", 15'h0, 4'd0, 8'hA2, 1'b0);

    // Sole requester with MAX_HOLD=2: two granted cycles, one idle, repeating.
    if3.req = 15'h0001;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c % 3 != 2) chk_rr2($sformatf("sole c%0d", c), 15'h0001, 4'd1, 8'hA0, 1'b1);
      else            chk_rr2($sformatf("sole c%0d", c), 15'h0000, 4'd0, 8'hA0, 1'b0);
    end
    if3.req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
